// File: rtl/midstate_loader.sv
// Assembles a framed SPI byte stream into the SHA-256 midstate and block-2 tail.
// A frame is SOF, 44 payload bytes, then an XOR checksum over the payload.
module midstate_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         request,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic [255:0] midstate,
  output logic [95:0]  block2_tail,
  output logic         received,
  output logic         busy,
  output logic         chk_err,
  output logic         timeout,
  output logic [7:0]   err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef logic [TW-1:0] tmo_t;
  localparam tmo_t TMO_LAST = tmo_t'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, LOAD, CHECK} state_t;

  state_t         state_q, state_d;
  logic [351:0]   shadow_q, shadow_d;
  logic [5:0]     byte_cnt_q, byte_cnt_d;
  logic [7:0]     xor_q, xor_d;
  tmo_t           tmo_cnt_q, tmo_cnt_d;
  logic [255:0]   midstate_q, midstate_d;
  logic [95:0]    tail_q, tail_d;
  logic           received_q, received_d;
  logic           chk_err_q, chk_err_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     err_count_q, err_count_d;
  logic           in_frame;
  logic           tmo_expire;
  logic [7:0]     err_inc;

  // Expiry fires on the edge the counter would reach TIMEOUT_CYCLES; a byte that same cycle wins.
  assign in_frame   = (state_q == LOAD) || (state_q == CHECK);
  assign tmo_expire = in_frame && !byte_valid && (tmo_cnt_q == TMO_LAST);
  assign err_inc    = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    byte_cnt_d  = byte_cnt_q;
    xor_d       = xor_q;
    tmo_cnt_d   = tmo_cnt_q;
    midstate_d  = midstate_q;
    tail_d      = tail_q;
    received_d  = 1'b0;
    chk_err_d   = 1'b0;
    timeout_d   = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      IDLE: begin
        if (request) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (byte_valid && byte_data == SOF_BYTE) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          xor_d      = '0;
          tmo_cnt_d  = '0;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          shadow_d   = {shadow_q[343:0], byte_data};
          byte_cnt_d = byte_cnt_q + 6'd1;
          xor_d      = xor_q ^ byte_data;
          tmo_cnt_d  = '0;
          if (byte_cnt_q == 6'd43) state_d = CHECK;
        end else if (tmo_expire) begin
          timeout_d   = 1'b1;
          err_count_d = err_inc;
          shadow_d    = '0;
          state_d     = WAIT_SOF;
        end else begin
          tmo_cnt_d = tmo_cnt_q + tmo_t'(1);
        end
      end
      CHECK: begin
        if (byte_valid) begin
          tmo_cnt_d = '0;
          if (byte_data == xor_q) begin
            midstate_d = shadow_q[351:96];
            tail_d     = shadow_q[95:0];
            received_d = 1'b1;
            state_d    = IDLE;
          end else begin
            chk_err_d   = 1'b1;
            err_count_d = err_inc;
            state_d     = WAIT_SOF;
          end
        end else if (tmo_expire) begin
          timeout_d   = 1'b1;
          err_count_d = err_inc;
          shadow_d    = '0;
          state_d     = WAIT_SOF;
        end else begin
          tmo_cnt_d = tmo_cnt_q + tmo_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      byte_cnt_q  <= '0;
      xor_q       <= '0;
      tmo_cnt_q   <= '0;
      midstate_q  <= '0;
      tail_q      <= '0;
      received_q  <= 1'b0;
      chk_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      byte_cnt_q  <= byte_cnt_d;
      xor_q       <= xor_d;
      tmo_cnt_q   <= tmo_cnt_d;
      midstate_q  <= midstate_d;
      tail_q      <= tail_d;
      received_q  <= received_d;
      chk_err_q   <= chk_err_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
    end
  end

  assign midstate    = midstate_q;
  assign block2_tail = tail_q;
  assign received    = received_q;
  assign chk_err     = chk_err_q;
  assign timeout     = timeout_q;
  assign err_count   = err_count_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_midstate_loader.sv
// Directed/randomized bench for midstate_loader; expected job registers are built
// straight from the frame payload, error counts from a saturating arithmetic model.
module tb_midstate_loader;

  localparam int         TMO = 16;
  localparam logic [7:0] SOF = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n, request, byte_valid;
  logic [7:0]   byte_data;
  logic [255:0] midstate;
  logic [95:0]  block2_tail;
  logic         received, busy, chk_err, timeout;
  logic [7:0]   err_count;

  midstate_loader #(.TIMEOUT_CYCLES(TMO), .SOF_BYTE(SOF)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .byte_valid(byte_valid),
    .byte_data(byte_data), .midstate(midstate), .block2_tail(block2_tail),
    .received(received), .busy(busy), .chk_err(chk_err), .timeout(timeout),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int recvSeen = 0, errSeen = 0, tmoSeen = 0;

  logic [7:0]   payload [44];
  logic [255:0] expMid;
  logic [95:0]  expTail;
  logic [7:0]   expErr;

  always @(negedge clk) begin
    if (received) recvSeen++;
    if (chk_err)  errSeen++;
    if (timeout)  tmoSeen++;
  end

  task automatic checkOutput(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of input drive; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic req, input logic vld, input logic [7:0] b);
    request = req; byte_valid = vld; byte_data = b;
    @(posedge clk); #1;
    request = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulseRequest();
    applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic fillPayload(input bit randomData);
    for (int i = 0; i < 44; i++)
      payload[i] = randomData ? 8'($urandom) : 8'(i + 1);
  endtask

  function automatic logic [7:0] payloadXor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 44; i++) x ^= payload[i];
    return x;
  endfunction

  function automatic logic [351:0] frameValue();
    logic [351:0] v = '0;
    for (int i = 0; i < 44; i++) v[351 - 8*i -: 8] = payload[i];
    return v;
  endfunction

  task automatic sendFrame(input bit withSof, input logic [7:0] chkMask);
    if (withSof) sendByte(SOF);
    for (int i = 0; i < 44; i++) sendByte(payload[i]);
    sendByte(payloadXor() ^ chkMask);
  endtask

  // Called right after the checksum edge of a frame expected to be accepted.
  task automatic checkGood(input string tag, input int recvBefore);
    logic [351:0] v;
    v = frameValue();
    expMid  = v[351:96];
    expTail = v[95:0];
    checkOutput({tag, "/received"}, received, 1'b1);
    checkOutput({tag, "/midstate"}, midstate, expMid);
    checkOutput({tag, "/tail"}, block2_tail, expTail);
    checkOutput({tag, "/busy"}, busy, 1'b0);
    checkOutput({tag, "/errCount"}, err_count, expErr);
    idle(1);
    checkOutput({tag, "/receivedDrop"}, received, 1'b0);
    checkOutput({tag, "/onePulse"}, recvSeen - recvBefore, 1);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "/midstate"}, midstate, 256'd0);
    checkOutput({tag, "/tail"}, block2_tail, 96'd0);
    checkOutput({tag, "/pulses"}, {received, chk_err, timeout, busy}, 4'b0000);
    checkOutput({tag, "/errCount"}, err_count, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, e0, t0, waited;
    logic [7:0] mask;
    rst_n = 1'b0; request = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    expMid = '0; expTail = '0; expErr = 8'h00;
    #12;
    checkZeroOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame while IDLE is ignored.
    fillPayload(1'b1);
    r0 = recvSeen;
    sendFrame(1'b1, 8'h00);
    idle(2);
    checkOutput("idleFrame/noRecv", recvSeen - r0, 0);
    checkOutput("idleFrame/busy", busy, 1'b0);
    checkOutput("idleFrame/midstate", midstate, 256'd0);

    // Request coinciding with SOF: that SOF is dropped, so the following bytes are noise.
    applyStimulus(1'b1, 1'b1, SOF);
    checkOutput("reqSof/busy", busy, 1'b1);
    fillPayload(1'b0);
    r0 = recvSeen;
    sendFrame(1'b0, 8'h00);
    idle(2);
    checkOutput("reqSof/noRecv", recvSeen - r0, 0);
    checkOutput("reqSof/stillArmed", busy, 1'b1);

    // Noise then the reference good frame.
    sendByte(8'h00); sendByte(8'hFF); sendByte(8'h5A);
    r0 = recvSeen;
    sendFrame(1'b1, 8'h00);
    checkGood("goodFrame", r0);
    checkOutput("goodFrame/msByte", midstate[255:248], 8'h01);
    checkOutput("goodFrame/lsByte", midstate[7:0], 8'h20);
    checkOutput("goodFrame/tailMs", block2_tail[95:88], 8'h21);
    checkOutput("goodFrame/tailLs", block2_tail[7:0], 8'h2C);

    // Bad checksum keeps old outputs and stays armed.
    pulseRequest();
    e0 = errSeen;
    fillPayload(1'b0);
    sendFrame(1'b1, 8'h01);
    expErr = 8'd1;
    checkOutput("badChk/pulse", chk_err, 1'b1);
    checkOutput("badChk/midstate", midstate, expMid);
    checkOutput("badChk/tail", block2_tail, expTail);
    checkOutput("badChk/errCount", err_count, expErr);
    checkOutput("badChk/busy", busy, 1'b1);
    idle(1);
    checkOutput("badChk/onePulse", errSeen - e0, 1);
    fillPayload(1'b1);
    r0 = recvSeen;
    sendFrame(1'b1, 8'h00);
    checkGood("afterBad", r0);

    // Inter-byte timeout after 10 payload bytes.
    pulseRequest();
    fillPayload(1'b1);
    sendByte(SOF);
    for (int i = 0; i < 10; i++) sendByte(payload[i]);
    waited = 0;
    while (!timeout && waited < 40) begin
      idle(1);
      waited++;
    end
    expErr = 8'd2;
    checkOutput("timeout/latency", waited, TMO);
    checkOutput("timeout/errCount", err_count, expErr);
    checkOutput("timeout/waitSof", busy, 1'b1);
    fillPayload(1'b1);
    r0 = recvSeen;
    sendFrame(1'b1, 8'h00);
    checkGood("afterTimeout", r0);

    // A byte arriving on the would-be expiry cycle suppresses the timeout.
    pulseRequest();
    fillPayload(1'b1);
    t0 = tmoSeen;
    r0 = recvSeen;
    sendByte(SOF);
    for (int i = 0; i < 5; i++) sendByte(payload[i]);
    idle(TMO - 1);
    for (int i = 5; i < 44; i++) sendByte(payload[i]);
    sendByte(payloadXor());
    checkGood("byteWins", r0);
    checkOutput("byteWins/noTimeout", tmoSeen - t0, 0);

    // Reset mid-frame clears everything; later frames need a new request.
    pulseRequest();
    fillPayload(1'b1);
    sendByte(SOF);
    for (int i = 0; i < 20; i++) sendByte(payload[i]);
    rst_n = 1'b0;
    #1;
    expMid = '0; expTail = '0; expErr = 8'h00;
    checkZeroOutputs("midReset");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    r0 = recvSeen;
    sendFrame(1'b1, 8'h00);
    idle(2);
    checkOutput("postReset/noRecv", recvSeen - r0, 0);
    checkOutput("postReset/busy", busy, 1'b0);
    checkOutput("postReset/midstate", midstate, 256'd0);

    // 256 consecutive bad frames saturate the error count.
    pulseRequest();
    for (int f = 0; f < 256; f++) begin
      fillPayload(1'b1);
      mask = 8'($urandom_range(1, 255));
      sendFrame(1'b1, mask);
      expErr = (expErr == 8'hFF) ? 8'hFF : expErr + 8'd1;
      if (f >= 250) begin
        checkOutput($sformatf("sat/chkErr%0d", f), chk_err, 1'b1);
        checkOutput($sformatf("sat/errCount%0d", f), err_count, expErr);
      end
    end
    checkOutput("sat/final", err_count, 8'hFF);
    checkOutput("sat/midstateHeld", midstate, 256'd0);

    // Still armed: good random frames, with fresh requests after the first.
    for (int k = 0; k < 3; k++) begin
      if (k != 0) pulseRequest();
      idle($urandom_range(0, 3));
      fillPayload(1'b1);
      r0 = recvSeen;
      sendFrame(1'b1, 8'h00);
      checkGood($sformatf("random%0d", k), r0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
